// File: rtl/log2_pkg.sv
// Shared types, default widths and width helper for the log2 unit.
package log2_pkg;

  localparam int unsigned log2_width_gp     = 32;
  localparam int unsigned log2_exp_width_gp = 32;

  typedef enum logic [1:0] {
    eS_IDLE = 2'd0,
    eS_BUSY = 2'd1,
    eS_DONE = 2'd2
  } log2_state_e;

  // Counter width needed to hold any bit index of a width-bit operand.
  function automatic int unsigned log2_cnt_width_gp(input int unsigned width);
    return int'($clog2(width));
  endfunction

endpackage

// File: rtl/log2_shifter.sv
// Datapath for log2: right-shifts the operand until only bit 0 may remain,
// counting shifts and remembering whether any set bit was shifted out.
module log2_shifter
  import log2_pkg::*;
#(
  parameter int unsigned width_p     = log2_width_gp,
  parameter int unsigned cnt_width_p = log2_cnt_width_gp(log2_width_gp)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   load_i,
  input  logic                   shift_i,
  input  logic [width_p-1:0]     data_i,
  output logic [cnt_width_p-1:0] cnt_o,
  output logic                   stk_o,
  output logic                   last_o
);

  logic [width_p-1:0]     sr_r;
  logic [cnt_width_p-1:0] cnt_r;
  logic                   stk_r;

  // Load a fresh operand or take one shift step; sticky collects lost ones.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sr_r  <= '0;
      cnt_r <= '0;
      stk_r <= 1'b0;
    end else if (load_i) begin
      sr_r  <= data_i;
      cnt_r <= '0;
      stk_r <= 1'b0;
    end else if (shift_i) begin
      sr_r  <= sr_r >> 1;
      cnt_r <= cnt_r + cnt_width_p'(1);
      stk_r <= stk_r | sr_r[0];
    end
  end

  assign last_o = (sr_r[width_p-1:1] == '0);
  assign cnt_o  = cnt_r;
  assign stk_o  = stk_r;

endmodule

// File: rtl/log2.sv
// Iterative floor(log2(x)) unit with ready/valid input and valid/yumi output.
module log2
  import log2_pkg::*;
#(
  parameter int unsigned width_p     = log2_width_gp,
  parameter int unsigned exp_width_p = log2_exp_width_gp
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     data_i,
  input  logic                   v_i,
  output logic                   ready_o,
  output logic [exp_width_p-1:0] exp_o,
  output logic                   zero_o,
  output logic                   pow2_o,
  output logic                   v_o,
  input  logic                   yumi_i
);

  localparam int unsigned cnt_width_lp = log2_cnt_width_gp(width_p);

  log2_state_e             state_r, state_n;
  logic                    load, shift, last, stk, zero_r, done;
  logic [cnt_width_lp-1:0] cnt;

  log2_shifter #(
    .width_p    (width_p),
    .cnt_width_p(cnt_width_lp)
  ) shifter (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .load_i (load),
    .shift_i(shift),
    .data_i (data_i),
    .cnt_o  (cnt),
    .stk_o  (stk),
    .last_o (last)
  );

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= eS_IDLE;
    else         state_r <= state_n;
  end

  // Zero flag captured with the operand; the shifter cannot tell 0 from 1.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)   zero_r <= 1'b0;
    else if (load) zero_r <= (data_i == '0);
  end

  // Next-state and datapath enables.
  always_comb begin
    state_n = state_r;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_r)
      eS_IDLE: begin
        if (v_i) begin
          load    = 1'b1;
          state_n = eS_BUSY;
        end
      end
      eS_BUSY: begin
        if (last) state_n = eS_DONE;
        else      shift   = 1'b1;
      end
      eS_DONE: begin
        if (yumi_i) state_n = eS_IDLE;
      end
      default: state_n = eS_IDLE;
    endcase
  end

  // Outputs decode from state and registers only.
  assign done    = (state_r == eS_DONE);
  assign ready_o = (state_r == eS_IDLE);
  assign v_o     = done;
  assign exp_o   = done ? exp_width_p'(cnt) : '0;
  assign zero_o  = done & zero_r;
  assign pow2_o  = done & ~zero_r & ~stk;

endmodule

// File: tb/tb_log2.sv
// Self-checking bench for log2: directed cases plus randomized operands
// compared against a bit-scan reference model.
module tb_log2;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] data_i = '0;
  logic        v_i = 1'b0;
  logic        ready_o;
  logic [31:0] exp_o;
  logic        zero_o;
  logic        pow2_o;
  logic        v_o;
  logic        yumi_i = 1'b0;

  int checks = 0;
  int failures = 0;

  log2 dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .data_i (data_i),
    .v_i    (v_i),
    .ready_o(ready_o),
    .exp_o  (exp_o),
    .zero_o (zero_o),
    .pow2_o (pow2_o),
    .v_o    (v_o),
    .yumi_i (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: index of the highest set bit, 0 for x == 0.
  function automatic int ref_log2(input logic [31:0] x);
    int k = 0;
    for (int i = 0; i < 32; i++) if ((x >> i) != 0) k = i;
    return k;
  endfunction

  function automatic logic ref_pow2(input logic [31:0] x);
    return (x != 0) && ((x & (x - 32'd1)) == 0);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one operand, check latency and result, hold it for 'hold' cycles
  // (optionally poking v_i meanwhile), then pop it with yumi.
  task automatic run_op(input logic [31:0] x, input int hold, input logic poke);
    int lat;
    int k;
    int wait_cnt;
    k = ref_log2(x);
    wait_cnt = 0;
    while (!ready_o && wait_cnt < 64) begin
      tick();
      wait_cnt++;
    end
    check("ready_before_issue", 32'(ready_o), 32'd1);
    data_i = x;
    v_i = 1'b1;
    tick();
    v_i = 1'b0;
    data_i = $urandom;
    lat = 0;
    while (!v_o && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(k + 1));
    check("exp", exp_o, 32'(k));
    check("zero", 32'(zero_o), 32'(x == 0));
    check("pow2", 32'(pow2_o), 32'(ref_pow2(x)));
    check("ready_in_done", 32'(ready_o), 32'd0);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        v_i = (i % 2 == 0);
        data_i = 32'h0000_0003;
      end
      tick();
      check("hold_v", 32'(v_o), 32'd1);
      check("hold_exp", exp_o, 32'(k));
      check("hold_ready", 32'(ready_o), 32'd0);
    end
    v_i = 1'b0;
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    check("pop_v", 32'(v_o), 32'd0);
    check("pop_ready", 32'(ready_o), 32'd1);
  endtask

  initial begin
    int el[5];
    logic [31:0] x;
    el = '{0, 1, 7, 15, 31};

    #2;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_v", 32'(v_o), 32'd0);
    check("rst_exp", exp_o, 32'd0);
    check("rst_zero", 32'(zero_o), 32'd0);
    check("rst_pow2", 32'(pow2_o), 32'd0);
    tick();
    tick();
    reset_i = 1'b0;
    tick();

    run_op(32'h0000_0001, 0, 1'b0);
    run_op(32'h8000_0000, 0, 1'b0);
    run_op(32'h0000_0000, 0, 1'b0);
    run_op(32'd12, 0, 1'b0);
    run_op(32'h0001_0000, 10, 1'b1);

    // Spurious yumi while idle.
    yumi_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_yumi_ready", 32'(ready_o), 32'd1);
      check("idle_yumi_v", 32'(v_o), 32'd0);
    end
    yumi_i = 1'b0;

    // Asynchronous reset in the middle of a long operation.
    data_i = 32'hFFFF_FFFF;
    v_i = 1'b1;
    tick();
    v_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("busy_before_rst", 32'(ready_o), 32'd0);
    #2;
    reset_i = 1'b1;
    #1;
    check("midrst_ready", 32'(ready_o), 32'd1);
    check("midrst_v", 32'(v_o), 32'd0);
    check("midrst_exp", exp_o, 32'd0);
    tick();
    reset_i = 1'b0;
    tick();
    check("postrst_v", 32'(v_o), 32'd0);
    run_op(32'd2, 0, 1'b0);

    // Round trip: a pow2 result 1<<e must come back as e with pow2 set.
    foreach (el[i]) run_op(32'd1 << el[i], 0, 1'b0);

    // Randomized operands spread across bit lengths.
    for (int n = 0; n < 40; n++) begin
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) x = '0;
      run_op(x, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
